gpio_cmd_responder: RTL

PL-side end of the PS→PL GPIO command bus. Synchronises the 32-bit GPIO word from the PS and detects each rising edge of the write-clock bit. It then decodes the 16-bit address and 8-bit data into one of three actions: a trigger pulse, a config-register write, or a readback request. Readback results return to the PS on a 32-bit GPIO output word with a toggle acknowledge. It sits between the PS GPIO IP and the config-register fabric and readback sources.

---
 rtl/gpio_cmd_responder_pkg.sv | 47 ++++
 rtl/gpio_sync.sv | 36 +++
 rtl/gpio_cmd_responder.sv | 171 +++++++++++++++++
 3 files changed

// File: rtl/gpio_cmd_responder_pkg.sv
// Shared definitions for the PS->PL GPIO command bus.
// Holds the GPIO field positions, the trigger and readback address constants,
// the reply-word bit positions, the responder state enum and an address-range helper.
package gpio_cmd_responder_pkg;

    localparam int unsigned GPIO_W = 32;
    localparam int unsigned ADDR_W = 16;
    localparam int unsigned DATA_W = 8;
    localparam int unsigned DROP_W = 8;

    // Fields of the incoming PS command word
    localparam int unsigned IN_ADDR_LSB = 0;
    localparam int unsigned IN_DATA_LSB = 16;
    localparam int unsigned IN_WCLK_BIT = 24;
    localparam int unsigned CMD_W       = IN_WCLK_BIT + 1;

    // Fields of the outgoing PS reply word
    localparam int unsigned OUT_DATA_LSB = 0;
    localparam int unsigned OUT_ADDR_LSB = 8;
    localparam int unsigned OUT_ACK_BIT  = 24;
    localparam int unsigned OUT_ERR_BIT  = 25;

    // Trigger and readback addresses
    localparam logic [ADDR_W-1:0] ADDR_RUN_TRIG = 16'h0000;
    localparam logic [ADDR_W-1:0] ADDR_DEL_TRIG = 16'h0001;
    localparam logic [ADDR_W-1:0] RB_ADDR_LO    = 16'h0006;
    localparam logic [ADDR_W-1:0] RB_ADDR_HI    = 16'h000B;

    // Command word as seen after synchronisation
    typedef struct packed {
        logic              w_clk;
        logic [DATA_W-1:0] data;
        logic [ADDR_W-1:0] addr;
    } gpio_cmd_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_CFG_WAIT,
        ST_RB_WAIT
    } state_t;

    // True when the address selects a readback source
    function automatic logic is_rb_addr(input logic [ADDR_W-1:0] a);
        return (a >= RB_ADDR_LO) && (a <= RB_ADDR_HI);
    endfunction

endpackage

// File: rtl/gpio_sync.sv
// N-stage, W-bit flip-flop synchroniser with asynchronous active-low clear.
// Ports: clk, clr_n (async clear, active low), din[W] (async input), dout[W] (synchronised).
module gpio_sync #(
    parameter int unsigned N = 2,
    parameter int unsigned W = 1
) (
    input  logic         clk,
    input  logic         clr_n,
    input  logic [W-1:0] din,
    output logic [W-1:0] dout
);

    logic [W-1:0] sync_q [N];
    logic [W-1:0] sync_d [N];

    // Shift chain: stage 0 samples the async input
    always_comb begin
        sync_d[0] = din;
        for (int unsigned i = 1; i < N; i++) begin
            sync_d[i] = sync_q[i-1];
        end
    end

    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            for (int unsigned i = 0; i < N; i++) begin
                sync_q[i] <= '0;
            end
        end else begin
            sync_q <= sync_d;
        end
    end

    assign dout = sync_q[N-1];

endmodule

// File: rtl/gpio_cmd_responder.sv
// PL-side responder for the PS->PL GPIO command bus.
// Synchronises the PS command word, detects w_clk rising edges and turns each
// command into a trigger pulse, a config write handshake or a readback request.
// Ports: clk, rst (async active low), gpio_in (PS command word),
//        run_trig/del_trig (1-cycle pulses), cfg_valid/cfg_addr/cfg_data/cfg_ready
//        (config write handshake), rb_req/rb_addr/rb_valid/rb_data (readback),
//        gpio_out (PS reply word with toggle ack), drop_cnt (saturating drop count).
module gpio_cmd_responder
    import gpio_cmd_responder_pkg::*;
#(
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned RB_TIMEOUT  = 255
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [GPIO_W-1:0] gpio_in,
    output logic              run_trig,
    output logic              del_trig,
    output logic              cfg_valid,
    output logic [ADDR_W-1:0] cfg_addr,
    output logic [DATA_W-1:0] cfg_data,
    input  logic              cfg_ready,
    output logic              rb_req,
    output logic [ADDR_W-1:0] rb_addr,
    input  logic              rb_valid,
    input  logic [DATA_W-1:0] rb_data,
    output logic [GPIO_W-1:0] gpio_out,
    output logic [DROP_W-1:0] drop_cnt
);

    localparam int unsigned CNT_W = (RB_TIMEOUT > 1) ? $clog2(RB_TIMEOUT + 1) : 1;
    localparam logic [DROP_W-1:0] DROP_MAX = {DROP_W{1'b1}};

    logic [CMD_W-1:0] s_word;
    gpio_cmd_t        s_cmd;
    logic             rise_c;
    logic             unused_gpio_c;

    state_t            state_q, state_d;
    logic              wclk_prev_q, wclk_prev_d;
    logic              run_trig_q, run_trig_d;
    logic              del_trig_q, del_trig_d;
    logic              cfg_valid_q, cfg_valid_d;
    logic [ADDR_W-1:0] cfg_addr_q, cfg_addr_d;
    logic [DATA_W-1:0] cfg_data_q, cfg_data_d;
    logic              rb_req_q, rb_req_d;
    logic [ADDR_W-1:0] rb_addr_q, rb_addr_d;
    logic [GPIO_W-1:0] gpio_out_q, gpio_out_d;
    logic [DROP_W-1:0] drop_cnt_q, drop_cnt_d;
    logic [CNT_W-1:0]  to_cnt_q, to_cnt_d;

    // Only the addr/data/w_clk bits carry information; upper bits are reserved
    gpio_sync #(.N(SYNC_STAGES), .W(CMD_W)) u_sync (
        .clk   (clk),
        .clr_n (rst),
        .din   (gpio_in[CMD_W-1:0]),
        .dout  (s_word)
    );
    assign unused_gpio_c = ^gpio_in[GPIO_W-1:CMD_W];

    assign s_cmd.addr  = s_word[IN_ADDR_LSB +: ADDR_W];
    assign s_cmd.data  = s_word[IN_DATA_LSB +: DATA_W];
    assign s_cmd.w_clk = s_word[IN_WCLK_BIT];

    // Reset clears wclk_prev, so a w_clk already high after reset counts as a rise
    assign rise_c = s_cmd.w_clk & ~wclk_prev_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= ST_IDLE;
            wclk_prev_q <= 1'b0;
            run_trig_q  <= 1'b0;
            del_trig_q  <= 1'b0;
            cfg_valid_q <= 1'b0;
            cfg_addr_q  <= '0;
            cfg_data_q  <= '0;
            rb_req_q    <= 1'b0;
            rb_addr_q   <= '0;
            gpio_out_q  <= '0;
            drop_cnt_q  <= '0;
            to_cnt_q    <= '0;
        end else begin
            state_q     <= state_d;
            wclk_prev_q <= wclk_prev_d;
            run_trig_q  <= run_trig_d;
            del_trig_q  <= del_trig_d;
            cfg_valid_q <= cfg_valid_d;
            cfg_addr_q  <= cfg_addr_d;
            cfg_data_q  <= cfg_data_d;
            rb_req_q    <= rb_req_d;
            rb_addr_q   <= rb_addr_d;
            gpio_out_q  <= gpio_out_d;
            drop_cnt_q  <= drop_cnt_d;
            to_cnt_q    <= to_cnt_d;
        end
    end

    // Command decode, handshakes and reply generation
    always_comb begin
        state_d     = state_q;
        wclk_prev_d = s_cmd.w_clk;
        run_trig_d  = 1'b0;
        del_trig_d  = 1'b0;
        cfg_valid_d = cfg_valid_q;
        cfg_addr_d  = cfg_addr_q;
        cfg_data_d  = cfg_data_q;
        rb_req_d    = rb_req_q;
        rb_addr_d   = rb_addr_q;
        gpio_out_d  = gpio_out_q;
        drop_cnt_d  = drop_cnt_q;
        to_cnt_d    = to_cnt_q;

        // Any rise while busy is lost, including one coinciding with the exit cycle
        if (rise_c && (state_q != ST_IDLE) && (drop_cnt_q != DROP_MAX)) begin
            drop_cnt_d = drop_cnt_q + DROP_W'(1);
        end

        unique case (state_q)
            ST_IDLE: begin
                if (rise_c) begin
                    if (s_cmd.addr == ADDR_RUN_TRIG) begin
                        run_trig_d = 1'b1;
                    end else if (s_cmd.addr == ADDR_DEL_TRIG) begin
                        del_trig_d = 1'b1;
                    end else if (is_rb_addr(s_cmd.addr)) begin
                        rb_req_d  = 1'b1;
                        rb_addr_d = s_cmd.addr;
                        to_cnt_d  = '0;
                        state_d   = ST_RB_WAIT;
                    end else begin
                        cfg_valid_d = 1'b1;
                        cfg_addr_d  = s_cmd.addr;
                        cfg_data_d  = s_cmd.data;
                        state_d     = ST_CFG_WAIT;
                    end
                end
            end
            ST_CFG_WAIT: begin
                if (cfg_ready) begin
                    cfg_valid_d = 1'b0;
                    state_d     = ST_IDLE;
                end
            end
            ST_RB_WAIT: begin
                // A valid reply wins over a timeout in the same cycle
                if (rb_valid || (to_cnt_q == CNT_W'(RB_TIMEOUT))) begin
                    gpio_out_d[OUT_DATA_LSB +: DATA_W] = rb_valid ? rb_data : {DATA_W{1'b1}};
                    gpio_out_d[OUT_ADDR_LSB +: ADDR_W] = rb_addr_q;
                    gpio_out_d[OUT_ERR_BIT]            = ~rb_valid;
                    gpio_out_d[OUT_ACK_BIT]            = ~gpio_out_q[OUT_ACK_BIT];
                    rb_req_d                           = 1'b0;
                    state_d                            = ST_IDLE;
                end else begin
                    to_cnt_d = to_cnt_q + CNT_W'(1);
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign run_trig  = run_trig_q;
    assign del_trig  = del_trig_q;
    assign cfg_valid = cfg_valid_q;
    assign cfg_addr  = cfg_addr_q;
    assign cfg_data  = cfg_data_q;
    assign rb_req    = rb_req_q;
    assign rb_addr   = rb_addr_q;
    assign gpio_out  = gpio_out_q;
    assign drop_cnt  = drop_cnt_q;

endmodule
